// File: rtl/hero_anim_pkg.sv
// Shared types and frame-id layout for the hero animation sequencer.
// The optional DIE state is enabled by defining HERO_ANIM_DIE_EN.
package hero_anim_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      JUMP = 2'd2,
      DIE  = 2'd3
   } anim_state_e;

   localparam int FRAME_W = 4;

   localparam logic [FRAME_W-1:0] IDLE_ID  = 4'd0;
   localparam logic [FRAME_W-1:0] RUN_BASE = 4'd1;

   function automatic logic [FRAME_W-1:0] jump_base(input int run_frames);
      return FRAME_W'(1 + run_frames);
   endfunction

   function automatic logic [FRAME_W-1:0] die_id(input int run_frames,
                                                 input int jump_frames);
      return FRAME_W'(1 + run_frames + jump_frames);
   endfunction

   // Ids for the default sprite-sheet layout (5 run, 4 jump frames)
   localparam logic [FRAME_W-1:0] JUMP_BASE = jump_base(5);
   localparam logic [FRAME_W-1:0] DIE_ID    = die_id(5, 4);

endpackage

// File: rtl/hero_anim_sequencer_anim_cycle_counter.sv
// Tick-gated hold counter plus wrapping frame index with synchronous clear.
// Exposes the next index so callers can register outputs from next state.
module anim_cycle_counter #(
   parameter int HOLD   = 6,
   parameter int FRAMES = 5,
   parameter int IDX_W  = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tick_i,
   input  logic             clr_i,
   input  logic             adv_i,
   output logic [IDX_W-1:0] idx_o,
   output logic [IDX_W-1:0] idx_d_o
);

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   logic [HW-1:0]    hold_q, hold_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   always_comb begin
      hold_d = hold_q;
      idx_d  = idx_q;
      if (tick_i && clr_i) begin
         hold_d = '0;
         idx_d  = '0;
      end else if (tick_i && adv_i) begin
         if (hold_q == HW'(HOLD - 1)) begin
            hold_d = '0;
            idx_d  = (idx_q == IDX_W'(FRAMES - 1)) ? '0 : idx_q + 1'b1;
         end else begin
            hold_d = hold_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_q <= '0;
         idx_q  <= '0;
      end else begin
         hold_q <= hold_d;
         idx_q  <= idx_d;
      end
   end

   assign idx_o   = idx_q;
   assign idx_d_o = idx_d;

endmodule

// File: rtl/hero_anim_sequencer.sv
// Per-vblank hero sprite animation FSM: frame id, ROM base, mirror, status.
// Define HERO_ANIM_DIE_EN to enable the terminal DIE state driven by hit.
module hero_anim_sequencer
   import hero_anim_pkg::*;
#(
   parameter int RUN_FRAMES   = 5,
   parameter int JUMP_FRAMES  = 4,
   parameter int FRAME_HOLD   = 6,
   parameter int JUMP_TICKS   = 32,
   parameter int SPRITE_WORDS = 2640,
   parameter int ADDR_W       = 16
) (
   input  logic              vga_clk,
   input  logic              reset,
   input  logic              frame_tick,
   input  logic              move_left,
   input  logic              move_right,
   input  logic              jump_req,
   input  logic              hit,
   output logic [3:0]        anim_frame,
   output logic [ADDR_W-1:0] rom_base,
   output logic              facing_left,
   output logic              airborne,
   output logic              dead
);

   localparam int RIW = (RUN_FRAMES > 1)  ? $clog2(RUN_FRAMES)  : 1;
   localparam int JIW = (JUMP_FRAMES > 1) ? $clog2(JUMP_FRAMES) : 1;
   localparam int JCW = (JUMP_TICKS > 1)  ? $clog2(JUMP_TICKS)  : 1;

   localparam logic [FRAME_W-1:0] JMP_ID0 = jump_base(RUN_FRAMES);
   localparam logic [FRAME_W-1:0] DIE_FID = die_id(RUN_FRAMES, JUMP_FRAMES);

   anim_state_e state_q, state_d;

   logic [JCW-1:0]     jcnt_q, jcnt_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [ADDR_W-1:0]  rom_q, rom_d;
   logic               face_q, face_d;
   logic               air_q, dead_q;

   logic run_clr, run_adv, jmp_clr, jmp_adv;
   logic hit_en, dir_valid;

   logic [RIW-1:0] run_idx, run_idx_d;
   logic [JIW-1:0] jmp_idx, jmp_idx_d;

`ifdef HERO_ANIM_DIE_EN
   assign hit_en = hit;
`else
   logic unused_hit;
   assign unused_hit = hit;
   assign hit_en     = 1'b0;
`endif

   assign dir_valid = move_left ^ move_right;

   anim_cycle_counter #(
      .HOLD   (FRAME_HOLD),
      .FRAMES (RUN_FRAMES),
      .IDX_W  (RIW)
   ) u_run (
      .clk_i   (vga_clk),
      .rst_i   (reset),
      .tick_i  (frame_tick),
      .clr_i   (run_clr),
      .adv_i   (run_adv),
      .idx_o   (run_idx),
      .idx_d_o (run_idx_d)
   );

   anim_cycle_counter #(
      .HOLD   (FRAME_HOLD),
      .FRAMES (JUMP_FRAMES),
      .IDX_W  (JIW)
   ) u_jump (
      .clk_i   (vga_clk),
      .rst_i   (reset),
      .tick_i  (frame_tick),
      .clr_i   (jmp_clr),
      .adv_i   (jmp_adv),
      .idx_o   (jmp_idx),
      .idx_d_o (jmp_idx_d)
   );

   logic unused_idx;
   assign unused_idx = ^{run_idx, jmp_idx};

   always_comb begin
      state_d = state_q;
      jcnt_d  = jcnt_q;
      face_d  = face_q;
      run_clr = 1'b0;
      run_adv = 1'b0;
      jmp_clr = 1'b0;
      jmp_adv = 1'b0;
      if (frame_tick) begin
         if (hit_en) begin
            state_d = DIE;
         end else begin
            if (dir_valid && state_q != DIE) face_d = move_left;
            unique case (state_q)
               IDLE, RUN: begin
                  if (jump_req) begin
                     state_d = JUMP;
                     jmp_clr = 1'b1;
                     jcnt_d  = '0;
                  end else if (!dir_valid) begin
                     state_d = IDLE;
                  end else if (state_q == IDLE) begin
                     state_d = RUN;
                     run_clr = 1'b1;
                  end else begin
                     run_adv = 1'b1;
                  end
               end
               JUMP: begin
                  // jump_req is deliberately ignored while airborne
                  if (jcnt_q == JCW'(JUMP_TICKS - 1)) begin
                     state_d = dir_valid ? RUN : IDLE;
                     run_clr = dir_valid;
                  end else begin
                     jcnt_d  = jcnt_q + 1'b1;
                     jmp_adv = 1'b1;
                  end
               end
               DIE: state_d = DIE;
            endcase
         end
      end
   end

   always_comb begin
      frame_d = IDLE_ID;
      unique case (state_d)
         IDLE: frame_d = IDLE_ID;
         RUN:  frame_d = RUN_BASE + FRAME_W'(run_idx_d);
         JUMP: frame_d = JMP_ID0 + FRAME_W'(jmp_idx_d);
         DIE:  frame_d = DIE_FID;
      endcase
      rom_d = ADDR_W'(int'(frame_d) * SPRITE_WORDS);
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state_q <= IDLE;
         jcnt_q  <= '0;
         face_q  <= 1'b0;
         frame_q <= '0;
         rom_q   <= '0;
         air_q   <= 1'b0;
         dead_q  <= 1'b0;
      end else if (frame_tick) begin
         state_q <= state_d;
         jcnt_q  <= jcnt_d;
         face_q  <= face_d;
         frame_q <= frame_d;
         rom_q   <= rom_d;
         air_q   <= (state_d == JUMP);
         dead_q  <= (state_d == DIE);
      end
   end

   assign anim_frame  = frame_q;
   assign rom_base    = rom_q;
   assign facing_left = face_q;
   assign airborne    = air_q;
   assign dead        = dead_q;

endmodule

// File: tb/tb_hero_anim_sequencer.sv
// Directed self-checking bench for hero_anim_sequencer.
// Define HERO_ANIM_DIE_EN to exercise the DIE state checks.
module tb_hero_anim_sequencer;

   logic        vga_clk = 1'b0;
   logic        reset, frame_tick, move_left, move_right, jump_req, hit;
   logic [3:0]  anim_frame;
   logic [15:0] rom_base;
   logic        facing_left, airborne, dead;

   int checks = 0;
   int errors = 0;

   hero_anim_sequencer dut (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .move_left   (move_left),
      .move_right  (move_right),
      .jump_req    (jump_req),
      .hit         (hit),
      .anim_frame  (anim_frame),
      .rom_base    (rom_base),
      .facing_left (facing_left),
      .airborne    (airborne),
      .dead        (dead)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct {
      string      name;
      logic       rst, tick, ml, mr, jr, ht;
      logic [3:0] frame;
      int         rom;
      logic       face, air, dd;
   } vec_t;

   vec_t vecs[8];

   task automatic cyc(input logic r, t, l, rr, j, h);
      reset      = r;
      frame_tick = t;
      move_left  = l;
      move_right = rr;
      jump_req   = j;
      hit        = h;
      @(posedge vga_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] f, input int rb,
                      input logic fl, input logic ai, input logic de);
      checks++;
      if (anim_frame !== f || rom_base !== 16'(rb) || facing_left !== fl ||
          airborne !== ai || dead !== de) begin
         errors++;
         $display("FAIL %s: got frame=%0d rom=%0d face=%b air=%b dead=%b, want frame=%0d rom=%0d face=%b air=%b dead=%b",
                  nm, anim_frame, rom_base, facing_left, airborne, dead,
                  f, rb, fl, ai, de);
      end
   endtask

   initial begin
      vecs[0] = '{"reset",     1,0,0,0,0,0, 0,     0, 0,0,0};
      vecs[1] = '{"idle_tick", 0,1,0,0,0,0, 0,     0, 0,0,0};
      vecs[2] = '{"run_start", 0,1,0,1,0,0, 1,  2640, 0,0,0};
      vecs[3] = '{"no_tick",   0,0,1,0,1,1, 1,  2640, 0,0,0};
      vecs[4] = '{"face_left", 0,1,1,0,0,0, 1,  2640, 1,0,0};
      vecs[5] = '{"both_dirs", 0,1,1,1,0,0, 0,     0, 1,0,0};
      vecs[6] = '{"jump_idle", 0,1,0,0,1,0, 6, 15840, 1,1,0};
      vecs[7] = '{"rst_jump",  1,1,0,1,1,0, 0,     0, 0,0,0};

      cyc(1,0,0,0,0,0);
      for (int i = 0; i < 8; i++) begin
         cyc(vecs[i].rst, vecs[i].tick, vecs[i].ml, vecs[i].mr,
             vecs[i].jr, vecs[i].ht);
         chk(vecs[i].name, vecs[i].frame, vecs[i].rom,
             vecs[i].face, vecs[i].air, vecs[i].dd);
      end

      // Ten idle ticks after reset
      cyc(1,0,0,0,0,0);
      chk("reset_state", 0, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) cyc(0,1,0,0,0,0);
      chk("idle_10", 0, 0, 0, 0, 0);

      // Run cycle with hold and wrap
      for (int k = 1; k <= 31; k++) begin
         cyc(0,1,0,1,0,0);
         if (k == 1)  chk("run_t1", 1, 2640, 0, 0, 0);
         if (k == 6)  chk("run_t6", 1, 2640, 0, 0, 0);
         if (k == 7)  chk("run_t7", 2, 5280, 0, 0, 0);
         if (k == 30) chk("run_t30", 5, 13200, 0, 0, 0);
         if (k == 31) chk("run_wrap", 1, 2640, 0, 0, 0);
      end

      // Jump from run, jump_req toggling ignored, land running
      cyc(0,1,0,1,1,0);
      chk("jump_T", 6, 15840, 0, 1, 0);
      for (int k = 1; k <= 32; k++) begin
         cyc(0,1,0,1,logic'(k[0]),0);
         if (k == 5)  chk("jump_T5", 6, 15840, 0, 1, 0);
         if (k == 6)  chk("jump_T6", 7, 18480, 0, 1, 0);
         if (k == 24) chk("jump_wrap", 6, 15840, 0, 1, 0);
         if (k == 31) chk("jump_T31", 7, 18480, 0, 1, 0);
         if (k == 32) chk("land_run", 1, 2640, 0, 0, 0);
      end

      // Jump without direction lands idle even with jump_req held
      cyc(0,1,0,0,1,0);
      chk("jump2_T", 6, 15840, 0, 1, 0);
      for (int k = 1; k <= 32; k++) cyc(0,1,0,0,logic'(k == 32),0);
      chk("land_idle", 0, 0, 0, 0, 0);

      // No ticks for 1000 cycles: everything holds
      cyc(0,1,1,0,0,0);
      chk("run_left", 1, 2640, 1, 0, 0);
      for (int k = 1; k <= 1000; k++) begin
         cyc(0,0,logic'($urandom_range(1)),logic'($urandom_range(1)),
             logic'($urandom_range(1)),logic'($urandom_range(1)));
         if (k % 250 == 0) chk("hold_no_tick", 1, 2640, 1, 0, 0);
      end

      // Reset mid-jump
      cyc(0,1,1,0,1,0);
      cyc(0,1,0,0,0,0);
      chk("mid_jump", 6, 15840, 1, 1, 0);
      cyc(1,0,0,0,0,0);
      chk("reset_mid_jump", 0, 0, 0, 0, 0);

`ifdef HERO_ANIM_DIE_EN
      cyc(0,1,0,1,1,1);
      chk("die", 10, 26400, 0, 0, 1);
      for (int k = 0; k < 8; k++) cyc(0,1,1,0,1,logic'(k[0]));
      chk("die_held", 10, 26400, 0, 0, 1);
      cyc(1,0,0,0,0,0);
      chk("die_reset", 0, 0, 0, 0, 0);
`else
      cyc(0,1,0,1,0,1);
      chk("hit_ignored", 1, 2640, 0, 0, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
